// File: rtl/conv_l2_sched.sv
// Layer-2 convolution sequencer: walks output positions, requests per-channel windows, accumulates psums.
// Build option CONV_L2_RELU_EN selects ReLU+saturation; default is signed saturation.
module conv_l2_sched #(
  parameter int F     = 14,
  parameter int B     = 8,
  parameter int ICH   = 16,
  parameter int OCH   = 32,
  parameter int PW    = 20,
  parameter int AW    = 24,
  parameter int SHIFT = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_win_req,
  output logic [3:0]        o_win_row,
  output logic [3:0]        o_win_col,
  output logic [3:0]        o_win_ich,
  input  logic              i_win_ack,
  input  logic              i_psum_valid,
  input  logic [OCH*PW-1:0] i_psum,
  input  logic [OCH*B-1:0]  i_bias,
  output logic [OCH*B-1:0]  o_data,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int RW = $clog2(ICH + 1);
  localparam logic [3:0]        LAST_POS = 4'(F - 3);
  localparam logic [3:0]        LAST_ICH = 4'(ICH - 1);
  localparam logic [RW-1:0]     FULL_CNT = RW'(ICH);
  localparam logic signed [AW:0] SAT_HI  = (AW+1)'(2 ** (B - 1) - 1);
`ifndef CONV_L2_RELU_EN
  localparam logic signed [AW:0] SAT_LO  = (AW+1)'(-(2 ** (B - 1)));
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_t;

  state_t state, state_nxt;
  logic [3:0] row, col, ich;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic signed [AW-1:0] acc     [OCH];
  logic signed [AW-1:0] acc_nxt [OCH];
  logic [OCH*B-1:0] result;
  logic signed [PW-1:0] psum_k;
  logic signed [B-1:0]  bias_k;
  logic signed [AW:0]   sum_k, shr_k;
  logic [B-1:0]         sat_k;
  logic accum_en, stray, last, out_fire, start_ok;

  // Psums are only absorbed while a position is in flight and not yet complete.
  assign accum_en = i_psum_valid && (state == REQ || state == WAIT) && (rcnt != FULL_CNT);
  assign stray    = i_psum_valid && !accum_en;
  assign rcnt_nxt = accum_en ? rcnt + RW'(1) : rcnt;
  assign last     = (state == WAIT) && (rcnt_nxt == FULL_CNT);
  assign out_fire = (state == OUT) && i_ready;
  assign start_ok = (state == IDLE) && i_start;

  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);
  assign o_valid   = (state == OUT);
  assign o_win_req = (state == REQ);
  assign o_win_row = row;
  assign o_win_col = col;
  assign o_win_ich = ich;

  always_comb begin
    result = '0;
    psum_k = '0;
    bias_k = '0;
    sum_k  = '0;
    shr_k  = '0;
    sat_k  = '0;
    for (int k = 0; k < OCH; k++) begin
      psum_k     = i_psum[k*PW +: PW];
      bias_k     = i_bias[k*B +: B];
      acc_nxt[k] = accum_en ? acc[k] + AW'(psum_k) : acc[k];
      sum_k      = (AW+1)'(acc_nxt[k]) + (AW+1)'(bias_k);
      shr_k      = sum_k >>> SHIFT;
`ifdef CONV_L2_RELU_EN
      if (shr_k[AW])            sat_k = '0;
      else if (shr_k > SAT_HI)  sat_k = SAT_HI[B-1:0];
      else                      sat_k = shr_k[B-1:0];
`else
      if (shr_k < SAT_LO)       sat_k = SAT_LO[B-1:0];
      else if (shr_k > SAT_HI)  sat_k = SAT_HI[B-1:0];
      else                      sat_k = shr_k[B-1:0];
`endif
      result[k*B +: B] = sat_k;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = REQ;
      REQ:  if (i_win_ack && ich == LAST_ICH) state_nxt = WAIT;
      WAIT: if (last) state_nxt = OUT;
      OUT:  if (i_ready) state_nxt = (col < LAST_POS || row < LAST_POS) ? REQ : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row    <= '0;
      col    <= '0;
      ich    <= '0;
      rcnt   <= '0;
      o_data <= '0;
      o_err  <= 1'b0;
      for (int k = 0; k < OCH; k++) acc[k] <= '0;
    end else begin
      if (start_ok || out_fire) begin
        rcnt <= '0;
        for (int k = 0; k < OCH; k++) acc[k] <= '0;
      end else if (accum_en) begin
        rcnt <= rcnt_nxt;
        for (int k = 0; k < OCH; k++) acc[k] <= acc_nxt[k];
      end
      if (start_ok) begin
        row <= '0;
        col <= '0;
        ich <= '0;
      end
      if (state == REQ && i_win_ack) ich <= (ich == LAST_ICH) ? 4'd0 : ich + 4'd1;
      if (out_fire) begin
        if (col < LAST_POS) begin
          col <= col + 4'd1;
        end else if (row < LAST_POS) begin
          col <= '0;
          row <= row + 4'd1;
        end
      end
      if (last) o_data <= result;
      // A stray arriving alongside an accepted start still gets flagged.
      if (start_ok) o_err <= 1'b0;
      if (stray)    o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_l2_sched.sv
// Directed bench for conv_l2_sched with a latency-configurable MAC engine responder.
// Expected clamp results follow CONV_L2_RELU_EN when it is defined.
module tb_conv_l2_sched;
  localparam int F = 14, B = 8, ICH = 16, OCH = 32, PW = 20, AW = 24, SHIFT = 6;
  localparam int NPOS = (F - 2) * (F - 2);
`ifdef CONV_L2_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
  logic win_ack = 1'b0, psum_valid = 1'b0;
  logic [OCH*PW-1:0] psum = '0;
  logic [OCH*B-1:0]  bias = '0;
  logic busy, done, err, win_req, valid;
  logic [3:0] win_row, win_col, win_ich;
  logic [OCH*B-1:0] data;

  conv_l2_sched dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done), .o_err(err),
    .o_win_req(win_req), .o_win_row(win_row), .o_win_col(win_col), .o_win_ich(win_ich),
    .i_win_ack(win_ack), .i_psum_valid(psum_valid), .i_psum(psum), .i_bias(bias),
    .o_data(data), .o_valid(valid), .i_ready(ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int ack_mode = 0, ich_dep = 0, lat = 3;
  int v0[OCH], v1[OCH];
  int due_q[$], ich_q[$], ich_log[$];
  int cyc = 0, done_cnt = 0, inj_req = 0, inj_seen = 0;
  logic tog = 1'b0, pend = 1'b0;
  logic [3:0] pend_ich, pend_row, pend_col, last_row, last_col;

  function automatic logic [OCH*PW-1:0] mk_psum(input int w_ich);
    logic [OCH*PW-1:0] r;
    int val;
    r = '0;
    for (int k = 0; k < OCH; k++) begin
      val = (w_ich == 0) ? v0[k] : v1[k];
      if (ich_dep != 0 && k == 3) val = 8 * w_ich;
      r[k*PW +: PW] = PW'(val);
    end
    return r;
  endfunction

  // Engine: accepts windows, returns one psum vector per window after lat cycles.
  always @(negedge clk) begin
    cyc++;
    tog = ~tog;
    psum_valid = 1'b0;
    if (rst) begin
      due_q.delete();
      ich_q.delete();
      pend = 1'b0;
      win_ack = 1'b0;
    end else begin
      if (pend) begin
        due_q.push_back(cyc + lat - 1);
        ich_q.push_back(int'(pend_ich));
        ich_log.push_back(int'(pend_ich));
        last_row = pend_row;
        last_col = pend_col;
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        psum = mk_psum(ich_q.pop_front());
        psum_valid = 1'b1;
      end else if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        psum = mk_psum(0);
        psum_valid = 1'b1;
      end
      win_ack  = win_req && (ack_mode == 0 || tog);
      pend     = win_ack;
      pend_ich = win_ich;
      pend_row = win_row;
      pend_col = win_col;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 400 && !valid; t++) @(negedge clk);
  endtask

  task automatic collect(input int first, input int n, input logic [OCH*B-1:0] exp);
    for (int i = 0; i < n; i++) begin
      wait_valid();
      chk($sformatf("valid #%0d", first + i), valid, 1);
      if (!valid) return;
      chk($sformatf("data #%0d", first + i), data, exp);
      chk($sformatf("pos #%0d", first + i), {last_row, last_col},
          {4'((first + i) / (F - 2)), 4'((first + i) % (F - 2))});
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_all64();
    for (int k = 0; k < OCH; k++) begin
      v0[k] = 64;
      v1[k] = 64;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [OCH*B-1:0] exp16, expv, held;
    int d0;
    exp16 = {OCH{8'h10}};
    set_all64();

    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst win_req", win_req, 0);
    chk("rst valid", valid, 0);
    chk("rst data", data, 0);
    chk("rst window", {win_row, win_col, win_ich}, 0);
    rst = 1'b0;

    // Full pass, uniform psums
    pulse_start();
    collect(0, NPOS, exp16);
    for (int t = 0; t < 20 && done_cnt == 0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pass1 done count", done_cnt, 1);
    chk("pass1 err", err, 0);
    chk("pass1 idle", busy, 0);

    // Clamp both directions
    v0[0] = 2000; v1[0] = 2000; v0[1] = -2000; v1[1] = -2000;
    pulse_start();
    expv = exp16;
    expv[7:0]  = 8'h7F;
    expv[15:8] = RELU ? 8'h00 : 8'h80;
    collect(0, 1, expv);
    do_reset();

    // Bias add and arithmetic shift of negative sums
    set_all64();
    v0[0] = -5; v1[0] = -4; v0[2] = -5; v1[2] = -4;
    bias[7:0] = 8'h01;
    bias[15:8] = 8'h80;
    pulse_start();
    expv = exp16;
    expv[7:0]   = RELU ? 8'h00 : 8'hFF;
    expv[15:8]  = 8'h0E;
    expv[23:16] = RELU ? 8'h00 : 8'hFE;
    collect(0, 1, expv);
    do_reset();
    bias = '0;
    set_all64();

    // Backpressure at (0,5) with an injected stray psum
    pulse_start();
    collect(0, 5, exp16);
    wait_valid();
    ready = 1'b0;
    chk("bp valid", valid, 1);
    chk("bp pos", {last_row, last_col}, {4'd0, 4'd5});
    held = data;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        chk("bp err before stray", err, 0);
        inj_req++;
      end
      @(negedge clk);
      chk($sformatf("bp hold data %0d", i), data, held);
      chk($sformatf("bp hold valid %0d", i), valid, 1);
      chk($sformatf("bp no req %0d", i), win_req, 0);
    end
    chk("bp err after stray", err, 1);
    ready = 1'b1;
    @(negedge clk);
    collect(6, 1, exp16);
    chk("bp err sticky", err, 1);
    do_reset();

    // Ack stalls on alternate cycles, channel-dependent psum, ignored restart
    ack_mode = 1;
    ich_dep = 1;
    ich_log.delete();
    pulse_start();
    expv = exp16;
    expv[31:24] = 8'h0F;
    collect(0, 1, expv);
    chk("stall ack count", ich_log.size(), ICH);
    for (int i = 0; i < ICH && i < ich_log.size(); i++)
      chk($sformatf("stall ich %0d", i), ich_log[i], i);
    pulse_start();
    collect(1, 2, expv);
    chk("restart ignored err", err, 0);
    chk("restart ignored busy", busy, 1);
    ack_mode = 0;
    ich_dep = 0;
    do_reset();

    // Asynchronous reset at output 70, then a clean full pass
    d0 = done_cnt;
    pulse_start();
    collect(0, 70, exp16);
    wait_valid();
    chk("pre-reset valid", valid, 1);
    rst = 1'b1;
    #1;
    chk("async rst valid", valid, 0);
    chk("async rst busy", busy, 0);
    chk("async rst win_req", win_req, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("no done after abort", done_cnt, d0);
    pulse_start();
    collect(0, NPOS, exp16);
    for (int t = 0; t < 20 && done_cnt == d0; t++) @(negedge clk);
    chk("pass2 done count", done_cnt, d0 + 1);
    chk("pass2 err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_l2_sched.md
Name: conv_l2_sched

Overview:
- Sequencer for layer-2 convolution. Walks the (F-2)x(F-2) valid output positions in row-major order.
- For each position it requests ICH 3x3 windows, one per input channel, from the line buffer. It accumulates the OCH partial sums that the shared MAC engine returns for each channel.
- It then adds bias, shifts, clamps and presents one OCH-wide 8-bit output word per position to the pooling stage.

Parameters:
- F, 14: input feature-map side; output side is F-2.
- B, 8: output bits per channel.
- ICH, 16: input channels accumulated per output position.
- OCH, 32: output channels produced in parallel.
- PW, 20: signed width of each engine partial sum.
- AW, 24: signed accumulator width.
- SHIFT, 6: arithmetic right shift applied after bias add.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  pulse; starts one full feature-map pass.
- o_busy  out  1  high from accepted start until the DONE cycle inclusive.
- o_done  out  1  one-cycle pulse after the last output is accepted.
- o_err  out  1  sticky: unexpected psum received; cleared by an accepted start.
- o_win_req  out  1  window request valid.
- o_win_row  out  4  window top row, 0..F-3.
- o_win_col  out  4  window left column, 0..F-3.
- o_win_ich  out  4  input channel of the window; also the engine weight-bank select.
- i_win_ack  in  1  request accepted; the engine starts a MAC on this window.
- i_psum_valid  in  1  engine partial-sum vector valid.
- i_psum  in  OCH*PW  signed partial sums; channel k occupies [k*PW +: PW].
- i_bias  in  OCH*B  signed bias; channel k occupies [k*B +: B].
- o_data  out  OCH*B  result; channel k occupies [k*B +: B].
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts o_data.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; row, col, ich, return count and accumulators all 0.
- FSM states: IDLE, REQ, WAIT, OUT, DONE.
- IDLE:
  - i_start -> clear accumulators, row=col=ich=0, rcnt=0, clear o_err, go to REQ.
  - Other inputs are ignored.
- REQ:
  - o_win_req=1 with the current row/col/ich.
  - On i_win_ack: if ich==ICH-1, set ich=0 and go to WAIT; otherwise ich+1.
  - Without i_win_ack: the request and its fields are held stable.
- Psum accumulation (any state except IDLE, DONE and OUT):
  - On i_psum_valid, acc[k] += sign-extend(i_psum[k]) for every k; rcnt+1.
  - Psums may arrive during REQ, overlapping later requests.
  - A psum_valid arriving when rcnt==ICH, or in IDLE, OUT or DONE, is dropped and sets o_err.
- WAIT:
  - When rcnt reaches ICH (including the cycle the ICH-th psum arrives), the result is computed from the final accumulator.
  - The result is registered into o_data with o_valid=1 on the next cycle, entering OUT.
  - Latency is 1 cycle from the last psum to o_valid.
- Result per channel:
  - s = acc + sign-extend(bias).
  - t = s >>> SHIFT (arithmetic).
  - Clamp per the Optional Feature.
  - No wrap-around is ever permitted.
- OUT:
  - o_data and o_valid are held until i_ready.
  - On handshake: o_valid=0, clear accumulators, rcnt=0.
  - If col<F-3: col+1, go to REQ.
  - Else if row<F-3: col=0, row+1, go to REQ.
  - Else go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. i_start in DONE or any busy state is ignored.
- Only one output position is outstanding at a time; the next position's requests are issued only after the OUT handshake.
- Asynchronous reset mid-pass: immediate return to the reset values. Partial results are discarded and no o_done is produced.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: CONV_L2_RELU_EN.
- Defined: ReLU plus saturation; t<0 -> 0, t>2^(B-1)-1 -> 2^(B-1)-1 (127).
- Undefined: signed saturation; t<-2^(B-1) -> -128, t>127 -> 127, otherwise t in two's complement.

Test Plan:
- Full pass: all psums = 64 per channel, bias 0, i_ready=1, engine latency 3 -> 144 outputs in row-major order, each channel = (16*64)>>6 = 16; single o_done; o_err=0.
- Clamp: psum ch0 = +2000 x16, ch1 = -2000 x16, bias 0 -> ch0=127; ch1=0 with RELU_EN, -128 without.
- Bias and shift rounding: psums sum to -65, bias +1 -> t=-1 (arithmetic shift); with RELU_EN -> 0, without -> 0xFF.
- Backpressure: hold i_ready=0 for 20 cycles at position (0,5) -> o_data stable, no o_win_req, psum stray flagged; o_err=1 only for the injected stray psum; next output is (0,6).
- Ack stalls: i_win_ack low on alternate cycles -> ich sequence 0..15 with no skips or repeats; accumulation correct; second i_start mid-pass ignored.
- Reset at output 70: assert i_rst -> o_valid, o_busy, o_win_req = 0 immediately; a fresh start produces 144 outputs beginning at (0,0).
